// File: rtl/alu_issue_rf.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_rf
//  Description : Operand-fetch / writeback stage around a combinational ALU,
//                with a small register file and valid/ready in/out streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_rf #(
    parameter int DW      = 32,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int CW      = 16,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_ctl,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [1:0]    alu_ctl,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    input  logic [DW-1:0] alu_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_rd,
    output logic [DW-1:0] out_res,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [CW-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rf [NREG];
    logic [1:0]    r_ctl;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [AW-1:0] r_out_rd;
    logic [DW-1:0] r_out_res;
    logic [CW-1:0] r_retired;

    logic          w_accept;
    logic [DW-1:0] w_rs1_val;
    logic [DW-1:0] w_rs2_val;
    logic          w_wb_en;
    logic          w_ld_ok;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;

    // r0 is masked on every read path so the hard-zero holds even for debug reads
    assign w_rs1_val = (ZERO_R0 && (in_rs1 == '0)) ? '0 : r_rf[in_rs1];
    assign w_rs2_val = (ZERO_R0 && (in_rs2 == '0)) ? '0 : r_rf[in_rs2];
    assign dbg_data  = (ZERO_R0 && (dbg_addr == '0)) ? '0 : r_rf[dbg_addr];

    assign w_wb_en   = (r_state == S_EXEC) && !(ZERO_R0 && (r_rd == '0));
    assign w_ld_ok   = ld_en && !(ZERO_R0 && (ld_addr == '0));

    assign alu_ctl   = r_ctl;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign out_valid = (r_state == S_DONE);
    assign out_rd    = r_out_rd;
    assign out_res   = r_out_res;
    assign retired   = r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_ctl     <= '0;
            r_rd      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_out_rd  <= '0;
            r_out_res <= '0;
            r_retired <= '0;
        end else begin
            // Writeback is ordered after the direct load so it wins on an address clash
            if (w_ld_ok) begin
                r_rf[ld_addr] <= ld_data;
            end
            if (w_wb_en) begin
                r_rf[r_rd] <= alu_res;
            end

            if (w_accept) begin
                r_ctl <= in_ctl;
                r_rd  <= in_rd;
                r_op1 <= w_rs1_val;
                r_op2 <= in_use_imm ? in_imm : w_rs2_val;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out_res <= alu_res;
                    r_out_rd  <= r_rd;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= w_accept ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
